// File: rtl/ula_muldiv_ctrl.sv
// Multicycle 8-bit unsigned multiply/divide sequencer.
// Drives the shared ULA one operation per clock; results held in registers.
module ula_muldiv_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rest,
    output logic             div_zero,
    output logic [2:0]       ula_ctrl,
    output logic [WIDTH-1:0] ula_srca,
    output logic [WIDTH-1:0] ula_srcb,
    input  logic [WIDTH-1:0] ula_result,
    input  logic             ula_z
);

    typedef enum logic [3:0] {
        IDLE, M_TEST, M_ADD, M_DEC, D_CHK, D_SLT, D_SUB, D_INC, DONE
    } state_t;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_SLT = 3'b111;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic             dz_r;

    always_comb begin
        ula_ctrl = ULA_AND;
        ula_srca = '0;
        ula_srcb = '0;
        case (state)
            M_TEST: begin ula_ctrl = ULA_OR;  ula_srca = cnt; end
            M_ADD:  begin ula_ctrl = ULA_ADD; ula_srca = acc; ula_srcb = a_r; end
            M_DEC:  begin ula_ctrl = ULA_SUB; ula_srca = cnt; ula_srcb = ONE; end
            D_CHK:  begin ula_ctrl = ULA_OR;  ula_srca = b_r; end
            D_SLT:  begin ula_ctrl = ULA_SLT; ula_srca = rem; ula_srcb = b_r; end
            D_SUB:  begin ula_ctrl = ULA_SUB; ula_srca = rem; ula_srcb = b_r; end
            D_INC:  begin ula_ctrl = ULA_ADD; ula_srca = acc; ula_srcb = ONE; end
            default: begin
                ula_ctrl = ULA_AND;
                ula_srca = '0;
                ula_srcb = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            cnt      <= '0;
            rem      <= '0;
            dz_r     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            rest     <= '0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        acc  <= '0;
                        dz_r <= 1'b0;
                        busy <= 1'b1;
                        if (op) begin
                            rem   <= a;
                            state <= D_CHK;
                        end else begin
                            cnt   <= b;
                            state <= M_TEST;
                        end
                    end
                end
                M_TEST: begin
                    if (ula_z) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= acc;
                        rest     <= '0;
                        div_zero <= 1'b0;
                    end else begin
                        state <= M_ADD;
                    end
                end
                M_ADD: begin
                    acc   <= ula_result;
                    state <= M_DEC;
                end
                M_DEC: begin
                    cnt   <= ula_result;
                    state <= M_TEST;
                end
                // Zero divisor is only flagged here and reported one cycle
                // later from D_SLT, so it completes at edge 2 like Q = 0.
                D_CHK: begin
                    dz_r  <= ula_z;
                    state <= D_SLT;
                end
                D_SLT: begin
                    if (dz_r) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= '1;
                        rest     <= a_r;
                        div_zero <= 1'b1;
                    end else if (!ula_z) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        result   <= acc;
                        rest     <= rem;
                        div_zero <= 1'b0;
                    end else begin
                        state <= D_SUB;
                    end
                end
                D_SUB: begin
                    rem   <= ula_result;
                    state <= D_INC;
                end
                D_INC: begin
                    acc   <= ula_result;
                    state <= D_SLT;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_muldiv_ctrl.sv
// Scoreboard bench for ula_muldiv_ctrl with a behavioural ULA model.
// Expected results and done edges are queued at start and popped on done.
module tb_ula_muldiv_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [7:0] rest;
    logic       div_zero;
    logic [2:0] ula_ctrl;
    logic [7:0] ula_srca;
    logic [7:0] ula_srcb;
    logic [7:0] ula_result;
    logic       ula_z;

    typedef struct {
        logic [7:0] res;
        logic [7:0] rem;
        logic       dz;
        int         done_at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   bad_ctrl = 0;

    ula_muldiv_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .rest(rest),
        .div_zero(div_zero), .ula_ctrl(ula_ctrl), .ula_srca(ula_srca),
        .ula_srcb(ula_srcb), .ula_result(ula_result), .ula_z(ula_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Unsigned compare: dividends up to 255 must order correctly.
    always_comb begin
        ula_result = 8'h00;
        case (ula_ctrl)
            3'b000: ula_result = ula_srca & ula_srcb;
            3'b001: ula_result = ula_srca | ula_srcb;
            3'b010: ula_result = ula_srca + ula_srcb;
            3'b110: ula_result = ula_srca - ula_srcb;
            3'b111: ula_result = {7'b0, ula_srca < ula_srcb};
            default: ula_result = 8'h00;
        endcase
        ula_z = (ula_result == 8'h00);
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [7:0] x,
                                   input logic [7:0] y, input int e0);
        exp_t e;
        int p;
        if (!o) begin
            p = int'(x) * int'(y);
            e.res = 8'(p % 256);
            e.rem = 8'h00;
            e.dz = 1'b0;
            e.done_at = e0 + 3 * int'(y) + 1;
        end else if (y == 8'h00) begin
            e.res = 8'hFF;
            e.rem = x;
            e.dz = 1'b1;
            e.done_at = e0 + 2;
        end else begin
            e.res = x / y;
            e.rem = x % y;
            e.dz = 1'b0;
            e.done_at = e0 + 3 * int'(x / y) + 2;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!(ula_ctrl inside {3'b000, 3'b001, 3'b010, 3'b110, 3'b111}))
            bad_ctrl++;
        if (!rst && done) begin
            if (q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", result, e.res);
                check("rest", rest, e.rem);
                check("div_zero", div_zero, e.dz);
                check("done_edge", cyc, e.done_at);
                check("busy_in_done", busy, 1);
            end
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", (n < 2000) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic run_op(input logic o, input logic [7:0] x,
                          input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        q.push_back(model(o, x, y, cyc));
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = ~o;
        drain();
    endtask

    initial begin
        int e0;
        int e1;
        exp_t e;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_rest", rest, 0);
        check("rst_ula_ctrl", ula_ctrl, 0);
        check("rst_srca", ula_srca, 0);
        rst = 1'b0;
        @(negedge clk);

        // Abort a long multiply with an asynchronous reset.
        start = 1'b1;
        op = 1'b0;
        a = 8'd9;
        b = 8'd200;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        while (cyc < e0 + 50) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_op(1'b0, 8'd3, 8'd4);

        run_op(1'b0, 8'd7, 8'd6);
        run_op(1'b0, 8'd20, 8'd13);
        run_op(1'b0, 8'd5, 8'd0);
        run_op(1'b0, 8'd255, 8'd255);
        run_op(1'b1, 8'd13, 8'd4);
        run_op(1'b1, 8'd3, 8'd7);
        run_op(1'b1, 8'd255, 8'd1);
        run_op(1'b1, 8'd50, 8'd0);
        run_op(1'b1, 8'd0, 8'd9);

        // start held high: one op per IDLE visit, operands taken at edge 0.
        @(negedge clk);
        start = 1'b1;
        op = 1'b0;
        a = 8'd5;
        b = 8'd3;
        @(negedge clk);
        e0 = cyc;
        e = model(1'b0, 8'd5, 8'd3, e0);
        q.push_back(e);
        e1 = e.done_at + 2;
        q.push_back(model(1'b1, 8'd20, 8'd6, e1));
        a = 8'd77;
        b = 8'd99;
        op = 1'b1;
        while (cyc < e1 - 1) @(negedge clk);
        a = 8'd20;
        b = 8'd6;
        @(negedge clk);
        a = 8'd200;
        b = 8'd1;
        while (cyc < e1 + 2) @(negedge clk);
        start = 1'b0;
        drain();

        check("ula_ctrl_legal", bad_ctrl, 0);
        check("queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
